rtmq_acsflg_bank: RTL and testbench
===================================

# rtmq_acsflg_bank

Register-bank access flag decoder for the RTMQ core. It decodes the packed ALU output bus for a contiguous window of NCH register addresses starting at BASE, and produces per-channel read and write flags delayed by a configurable LAT cycles. It also tracks immediate high/low segment pairs and latches a sticky collision error. One instance replaces NCH single-address flag decoders in front of a peripheral register bank.

## Interface
- BASE, default 0: first decoded register address; window is BASE..BASE+NCH-1.
- NCH, default 4: channel count, 1..32. BASE+NCH-1 must be ≤ 2^W_ADR-1, enforced by an elaboration check.
- LAT, default 1: flag latency in clk cycles, 1..4.
- W_REG, W_ADR and W_ALU come from the shared RTMQ header, with W_ALU = 3*W_REG + 4*W_ADR + 1.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out  in  W_ALU  ALU bus, packed MSB→LSB as {alu_res, alu_msk, alu_rda, alu_r0a, alu_r1a, imm_res, imm_rda, imm_seg}.
- en  in  1  bank enable; sampled with alu_out.
- err_clr  in  1  clears err_col.
- f_read  out  NCH  bit k set when alu_r0a or alu_r1a equals BASE+k.
- f_wrt_alu  out  NCH  bit k set when alu_rda equals BASE+k.
- f_wrt_ihi  out  NCH  bit k set when imm_rda equals BASE+k and imm_seg = 0.
- f_wrt_ilo  out  NCH  bit k set when imm_rda equals BASE+k and imm_seg = 1.
- f_imm_pair  out  NCH  bit k pulses when a low-segment write completes a high/low pair on channel k.
- f_any  out  1  OR of all bits of f_read, f_wrt_alu, f_wrt_ihi and f_wrt_ilo.
- err_col  out  1  sticky flag: ALU write and immediate write hit the same channel in the same cycle.

## Operation
- **Decode (stage 1):**
  - Each address field is compared against BASE+k in W_ADR+1 bits, so no wrap-around can alias.
  - Addresses outside the window produce no flags.
  - en = 0 forces all stage-1 decode results to 0. This also blocks pair-tracker updates and collision detection for that cycle.
- **Multiple hits:**
  - When alu_r0a and alu_r1a hit different channels, both read bits are set.
  - When they hit the same channel, that single bit is set.
  - Read and write flags may coexist on one channel.
- **Pipeline:** stage 1 is followed by LAT-1 register stages. All flag outputs, f_any, f_imm_pair and err_col updates share the same LAT alignment.
- **Pair tracker state:** a single pending entry {pnd_vld, pnd_idx}, updated at stage 1.
- **Pair tracker transitions, in priority order:**
  - High-segment write to channel j: pnd_vld = 1, pnd_idx = j. This replaces any previous pending entry.
  - Low-segment write to channel j with pnd_vld = 1 and pnd_idx = j: pulse f_imm_pair[j] and clear pnd_vld.
  - Low-segment write with no matching pending entry: no pulse; pnd_vld is cleared.
  - ALU write (alu_rda) to channel pnd_idx while pnd_vld = 1 and no immediate write hits in the same cycle: clear pnd_vld.
  - Immediate writes outside the window leave the tracker unchanged.
- **Collision:**
  - err_col sets when alu_rda and imm_rda both hit the window at the same channel.
  - It stays set until err_clr is high.
  - A set and a clear in the same effective cycle resolve as set.
  - Both flags are still emitted in a collision cycle.

## Timing
- **Reset:** asynchronous assertion clears every output to 0, all pipeline stages, pnd_vld, pnd_idx and err_col. Deassertion is taken on the next clk edge.
- **Latency:** a bus value sampled at edge n appears on the outputs after edge n+LAT-1. LAT = 1 gives one-register behaviour: flags valid the cycle after the bus.
- **Throughput:** one bus word per cycle, no stalls, no handshake.
- **Pulse widths:** all flags are single-cycle per bus word. Back-to-back accesses give back-to-back flags.
- **err_clr:** sampled directly, not delayed.
  - The clear takes effect on the edge after err_clr is high.
  - If a collision is in flight in the pipeline, err_col re-sets when that collision reaches the output stage.
- **Reset mid-operation:** in-flight flags and any pending pair are discarded. No pulse is emitted after reset.

## Test plan
- **Window decode** (BASE=8, NCH=4, LAT=2):
  - alu_r0a=9, alu_r1a=11, alu_rda=8 → two cycles later f_read=4'b1010, f_wrt_alu=4'b0001, f_any=1.
  - All addresses set to 12 or 7 → all flags 0.
- **Segment pair:**
  - imm_rda=10, seg=0, then next cycle imm_rda=10, seg=1 → f_wrt_ihi=4'b0100, then f_wrt_ilo=4'b0100 with f_imm_pair=4'b0100 in the same cycle.
  - Repeat with the low write to address 9 → no f_imm_pair.
- **Pair broken by ALU write:** ihi to 10, then alu_rda=10, then ilo to 10 → f_imm_pair stays 0 throughout.
- **Collision:**
  - alu_rda=imm_rda=11 → err_col=1 at LAT and held for 20 cycles.
  - err_clr pulse → err_col=0 one cycle later.
  - Collision and err_clr in the same cycle → err_col stays 1.
- **Enable and reset:**
  - en=0 with all addresses at 9 → all outputs 0.
  - rst_n low for 3 ns mid-pipeline with flags in flight → outputs 0 immediately; none appear after release.
- **Range edge:** BASE=252, NCH=4, W_ADR=8 → address 255 sets bit 3; address 0 sets nothing (no wrap).

Source files
------------

// File: rtl/rtmq_acsflg_bank.sv
// Access flag decoder for a window of NCH register addresses starting at BASE.
// Emits per-channel read/write flags, immediate high/low pair pulses and a sticky collision error.
module rtmq_acsflg_bank #(
    parameter int BASE  = 0,
    parameter int NCH   = 4,
    parameter int LAT   = 1,
    parameter int W_REG = 32,
    parameter int W_ADR = 8,
    parameter int W_ALU = 3 * W_REG + 4 * W_ADR + 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [W_ALU-1:0] alu_out_i,
    input  logic             en_i,
    input  logic             err_clr_i,
    output logic [NCH-1:0]   f_read_o,
    output logic [NCH-1:0]   f_wrt_alu_o,
    output logic [NCH-1:0]   f_wrt_ihi_o,
    output logic [NCH-1:0]   f_wrt_ilo_o,
    output logic [NCH-1:0]   f_imm_pair_o,
    output logic             f_any_o,
    output logic             err_col_o
);
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int P_IRDA = 1;
    localparam int P_IRES = P_IRDA + W_ADR;
    localparam int P_R1A  = P_IRES + W_REG;
    localparam int P_R0A  = P_R1A + W_ADR;
    localparam int P_RDA  = P_R0A + W_ADR;
    localparam int P_MSK  = P_RDA + W_ADR;

    generate
        if (NCH < 1 || NCH > 32) begin : g_bad_nch
            $error("rtmq_acsflg_bank: NCH must be in 1..32");
        end
        if (LAT < 1 || LAT > 4) begin : g_bad_lat
            $error("rtmq_acsflg_bank: LAT must be in 1..4");
        end
        if (BASE < 0 || longint'(BASE) + longint'(NCH) - 1 > (longint'(1) <<< W_ADR) - 1) begin : g_bad_win
            $error("rtmq_acsflg_bank: address window exceeds the W_ADR range");
        end
        if (W_ALU != 3 * W_REG + 4 * W_ADR + 1) begin : g_bad_alu
            $error("rtmq_acsflg_bank: W_ALU inconsistent with W_REG/W_ADR");
        end
    endgenerate

    typedef struct packed {
        logic [NCH-1:0] rd;
        logic [NCH-1:0] wa;
        logic [NCH-1:0] ihi;
        logic [NCH-1:0] ilo;
        logic [NCH-1:0] pair;
        logic           any;
        logic           col;
    } stage_t;

    logic [W_ADR-1:0] rda, r0a, r1a, irda;
    logic             seg;
    logic             unused_fields;

    assign seg  = alu_out_i[0];
    assign irda = alu_out_i[P_IRDA +: W_ADR];
    assign r1a  = alu_out_i[P_R1A +: W_ADR];
    assign r0a  = alu_out_i[P_R0A +: W_ADR];
    assign rda  = alu_out_i[P_RDA +: W_ADR];
    // Data payloads ride on the same bus but carry no address information.
    assign unused_fields = ^{alu_out_i[W_ALU-1:P_MSK], alu_out_i[P_IRES +: W_REG]};

    logic [NCH-1:0] hit_rd, hit_wa, hit_imm;
    logic [W_ADR:0] adr_k;
    logic [IW-1:0]  imm_idx;

    // One extra compare bit keeps BASE+k from aliasing onto low addresses.
    always_comb begin
        hit_rd  = '0;
        hit_wa  = '0;
        hit_imm = '0;
        adr_k   = '0;
        imm_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            adr_k      = (W_ADR + 1)'(BASE + k);
            hit_rd[k]  = en_i && (({1'b0, r0a} == adr_k) || ({1'b0, r1a} == adr_k));
            hit_wa[k]  = en_i && ({1'b0, rda} == adr_k);
            hit_imm[k] = en_i && ({1'b0, irda} == adr_k);
            if (hit_imm[k]) begin
                imm_idx = IW'(k);
            end
        end
    end

    stage_t         dec;
    logic           pnd_vld_q, pnd_vld_d;
    logic [IW-1:0]  pnd_idx_q, pnd_idx_d;

    always_comb begin
        dec       = '0;
        dec.rd    = hit_rd;
        dec.wa    = hit_wa;
        dec.ihi   = seg ? '0 : hit_imm;
        dec.ilo   = seg ? hit_imm : '0;
        dec.any   = |{hit_rd, hit_wa, hit_imm};
        dec.col   = |(hit_wa & hit_imm);
        pnd_vld_d = pnd_vld_q;
        pnd_idx_d = pnd_idx_q;
        if (|hit_imm) begin
            if (!seg) begin
                pnd_vld_d = 1'b1;
                pnd_idx_d = imm_idx;
            end else begin
                if (pnd_vld_q && (pnd_idx_q == imm_idx)) begin
                    dec.pair[imm_idx] = 1'b1;
                end
                pnd_vld_d = 1'b0;
            end
        end else if (pnd_vld_q && hit_wa[pnd_idx_q]) begin
            pnd_vld_d = 1'b0;
        end
    end

    stage_t stg_q [LAT];
    stage_t stg_d [LAT];
    logic   err_col_q;

    always_comb begin
        stg_d[0] = dec;
        for (int i = 1; i < LAT; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    // err_col is fed from the word entering the output stage so it lines up with the flags.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < LAT; i++) begin
                stg_q[i] <= '0;
            end
            pnd_vld_q <= 1'b0;
            pnd_idx_q <= '0;
            err_col_q <= 1'b0;
        end else begin
            for (int i = 0; i < LAT; i++) begin
                stg_q[i] <= stg_d[i];
            end
            pnd_vld_q <= pnd_vld_d;
            pnd_idx_q <= pnd_idx_d;
            err_col_q <= stg_d[LAT-1].col | (err_col_q & ~err_clr_i);
        end
    end

    assign f_read_o     = stg_q[LAT-1].rd;
    assign f_wrt_alu_o  = stg_q[LAT-1].wa;
    assign f_wrt_ihi_o  = stg_q[LAT-1].ihi;
    assign f_wrt_ilo_o  = stg_q[LAT-1].ilo;
    assign f_imm_pair_o = stg_q[LAT-1].pair;
    assign f_any_o      = stg_q[LAT-1].any;
    assign err_col_o    = err_col_q;

endmodule

// File: tb/tb_rtmq_acsflg_bank.sv
// Bench for rtmq_acsflg_bank: window at 8 (LAT=2) and window at 252 (LAT=1) share one bus;
// a behavioural model pushes expected flags per bus word, compared as the outputs arrive.
module tb_rtmq_acsflg_bank;
    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] wa;
        logic [3:0] ihi;
        logic [3:0] ilo;
        logic [3:0] pair;
        logic       any;
    } flg_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] idx;
    } pnd_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [128:0] bus;
    logic         en, clr;

    logic [3:0] a_rd, a_wa, a_ihi, a_ilo, a_pair;
    logic       a_any, a_err;
    logic [3:0] b_rd, b_wa, b_ihi, b_ilo, b_pair;
    logic       b_any, b_err;

    int n_chk, n_fail;

    flg_t exp_q[$], obs_q[$], expb_q[$], obsb_q[$];
    logic exp_err_q[$], obs_err_q[$];

    pnd_t pa, pb;
    logic m_col_dl, m_err;

    logic [7:0] addr_tab [16] = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13,
                                  8'd250, 8'd251, 8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1};

    always #5 clk = ~clk;

    rtmq_acsflg_bank #(.BASE(8), .NCH(4), .LAT(2)) u_a (
        .clk_i(clk), .rst_n_i(rst_n), .alu_out_i(bus), .en_i(en), .err_clr_i(clr),
        .f_read_o(a_rd), .f_wrt_alu_o(a_wa), .f_wrt_ihi_o(a_ihi), .f_wrt_ilo_o(a_ilo),
        .f_imm_pair_o(a_pair), .f_any_o(a_any), .err_col_o(a_err)
    );

    rtmq_acsflg_bank #(.BASE(252), .NCH(4), .LAT(1)) u_b (
        .clk_i(clk), .rst_n_i(rst_n), .alu_out_i(bus), .en_i(en), .err_clr_i(clr),
        .f_read_o(b_rd), .f_wrt_alu_o(b_wa), .f_wrt_ihi_o(b_ihi), .f_wrt_ilo_o(b_ilo),
        .f_imm_pair_o(b_pair), .f_any_o(b_any), .err_col_o(b_err)
    );

    function automatic logic [3:0] hit(input int base, input logic [7:0] a);
        hit = '0;
        for (int k = 0; k < 4; k++) begin
            if (int'(a) == base + k) hit[k] = 1'b1;
        end
    endfunction

    task automatic model_word(input int base, input logic [7:0] rda, r0a, r1a, irda,
                              input logic seg, e, inout pnd_t p, output flg_t f, output logic col);
        logic [3:0] rdh, wah, ih;
        int j;
        f = '0;
        col = 1'b0;
        if (e) begin
            rdh = hit(base, r0a) | hit(base, r1a);
            wah = hit(base, rda);
            ih  = hit(base, irda);
            j = 0;
            for (int k = 0; k < 4; k++) if (ih[k]) j = k;
            f.rd  = rdh;
            f.wa  = wah;
            f.ihi = seg ? 4'b0 : ih;
            f.ilo = seg ? ih : 4'b0;
            if (ih != 4'b0) begin
                if (!seg) begin
                    p.vld = 1'b1;
                    p.idx = 8'(j);
                end else begin
                    if (p.vld && int'(p.idx) == j) f.pair[j] = 1'b1;
                    p.vld = 1'b0;
                end
            end else if (p.vld && wah[p.idx]) begin
                p.vld = 1'b0;
            end
            f.any = |{rdh, wah, ih};
            col   = |(wah & ih);
        end
    endtask

    task automatic model_reset();
        pa = '0;
        pb = '0;
        m_col_dl = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic q_clear();
        exp_q.delete(); obs_q.delete(); expb_q.delete(); obsb_q.delete();
        exp_err_q.delete(); obs_err_q.delete();
    endtask

    // Called at a falling edge: records expectations, drives one bus word, captures after the next edge.
    task automatic step(input logic [7:0] rda, r0a, r1a, irda, input logic seg, e, c);
        flg_t fa, fb;
        logic ca, cb, arr;
        model_word(8, rda, r0a, r1a, irda, seg, e, pa, fa, ca);
        model_word(252, rda, r0a, r1a, irda, seg, e, pb, fb, cb);
        exp_q.push_back(fa);
        expb_q.push_back(fb);
        arr = m_col_dl;
        m_col_dl = ca;
        m_err = arr | (m_err & ~c);
        exp_err_q.push_back(m_err);
        bus = {32'($urandom()), 32'($urandom()), rda, r0a, r1a, 32'($urandom()), irda, seg};
        en  = e;
        clr = c;
        @(negedge clk);
        obs_q.push_back({a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any});
        obsb_q.push_back({b_rd, b_wa, b_ihi, b_ilo, b_pair, b_any});
        obs_err_q.push_back(a_err);
    endtask

    task automatic idle(input int n);
        repeat (n) step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        n_chk++;
        if ({a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected 0", {a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err});
        end
        n_chk++;
        if ({b_rd, b_wa, b_ihi, b_ilo, b_pair, b_any, b_err} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected 0", {b_rd, b_wa, b_ihi, b_ilo, b_pair, b_any, b_err});
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_release_a: got %h expected 0", {a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err});
        end
    endtask

    task automatic test_window();
        q_clear();
        step(8'd8, 8'd9, 8'd11, 8'd100, 1'b0, 1'b1, 1'b0);
        step(8'd12, 8'd7, 8'd12, 8'd7, 1'b1, 1'b1, 1'b0);
        step(8'd7, 8'd12, 8'd7, 8'd12, 1'b0, 1'b1, 1'b0);
        step(8'd9, 8'd10, 8'd10, 8'd100, 1'b0, 1'b1, 1'b0);
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL window_flags: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_pair();
        q_clear();
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b1, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd9, 1'b1, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd8, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd200, 1'b1, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd8, 1'b1, 1'b1, 1'b0);
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pair_flags: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_pair_break();
        q_clear();
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b0, 1'b1, 1'b0);
        step(8'd10, 8'd100, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b1, 1'b1, 1'b0);
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL pair_break_flags: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_collision();
        q_clear();
        step(8'd11, 8'd100, 8'd100, 8'd11, 1'b0, 1'b1, 1'b0);
        repeat (20) step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(8'd11, 8'd100, 8'd100, 8'd11, 1'b1, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b0);
        step(8'd11, 8'd100, 8'd100, 8'd11, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        idle(2);
        step(8'd11, 8'd100, 8'd100, 8'd11, 1'b0, 1'b1, 1'b1);
        idle(2);
        step(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 1'b0, 1'b1);
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL collision_flags: got %h expected %h", o, e);
            end
        end
        while (exp_err_q.size() > 0 && obs_err_q.size() > 0) begin
            logic e, o;
            e = exp_err_q.pop_front();
            o = obs_err_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL collision_err_col: got %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_enable();
        q_clear();
        step(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
        step(8'd9, 8'd9, 8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
        step(8'd9, 8'd9, 8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
        step(8'd9, 8'd9, 8'd9, 8'd9, 1'b1, 1'b0, 1'b0);
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL enable_flags: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        q_clear();
        step(8'd10, 8'd9, 8'd255, 8'd10, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd8, 8'd255, 8'd100, 1'b0, 1'b1, 1'b0);
        en  = 1'b0;
        clr = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err} !== 22'b0) begin
            n_fail++;
            $display("FAIL reset_mid_a: got %h expected 0", {a_rd, a_wa, a_ihi, a_ilo, a_pair, a_any, a_err});
        end
        n_chk++;
        if ({b_rd, b_wa, b_ihi, b_ilo, b_pair, b_any} !== 21'b0) begin
            n_fail++;
            $display("FAIL reset_mid_b: got %h expected 0", {b_rd, b_wa, b_ihi, b_ilo, b_pair, b_any});
        end
        #2 rst_n = 1'b1;
        model_reset();
        q_clear();
        @(negedge clk);
        step(8'd100, 8'd100, 8'd100, 8'd10, 1'b1, 1'b1, 1'b0);
        idle(3);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_flags: got %h expected %h", o, e);
            end
        end
        while (exp_err_q.size() > 0 && obs_err_q.size() > 0) begin
            logic e, o;
            e = exp_err_q.pop_front();
            o = obs_err_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid_err_col: got %b expected %b", o, e);
            end
        end
    endtask

    task automatic test_range_edge();
        q_clear();
        step(8'd100, 8'd255, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0);
        step(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0);
        step(8'd255, 8'd252, 8'd253, 8'd254, 1'b1, 1'b1, 1'b0);
        step(8'd251, 8'd251, 8'd251, 8'd251, 1'b0, 1'b1, 1'b0);
        idle(1);
        while (expb_q.size() > 0 && obsb_q.size() > 0) begin
            flg_t e, o;
            e = expb_q.pop_front();
            o = obsb_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL range_edge_flags: got %h expected %h", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        q_clear();
        step(8'd100, 8'd8, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd9, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0);
        step(8'd100, 8'd10, 8'd100, 8'd100, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(addr_tab[$urandom_range(0, 15)], addr_tab[$urandom_range(0, 15)],
                 addr_tab[$urandom_range(0, 15)], addr_tab[$urandom_range(0, 15)],
                 1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 15) == 0));
        end
        idle(2);
        void'(obs_q.pop_front());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            flg_t e, o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_flags_a: got %h expected %h", o, e);
            end
        end
        while (expb_q.size() > 0 && obsb_q.size() > 0) begin
            flg_t e, o;
            e = expb_q.pop_front();
            o = obsb_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_flags_b: got %h expected %h", o, e);
            end
        end
        while (exp_err_q.size() > 0 && obs_err_q.size() > 0) begin
            logic e, o;
            e = exp_err_q.pop_front();
            o = obs_err_q.pop_front();
            n_chk++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b_err_col: got %b expected %b", o, e);
            end
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus    = '0;
        en     = 1'b0;
        clr    = 1'b0;
        model_reset();
        test_reset();
        test_window();
        test_pair();
        test_pair_break();
        test_collision();
        test_enable();
        test_reset_mid();
        test_range_edge();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
